// File: rtl/gate_driver_spi_arbiter_pkg.sv
// Shared parameters and state encoding for the gate-driver SPI arbiter.
package gate_driver_spi_arbiter_pkg;

    // Default SPI frame width and read-address width used across the project.
    localparam int SPI_FRAME_WIDTH = 16;
    localparam int DATA_WIDTH      = 16;

    // Arbiter transaction states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESPOND   = 2'd3
    } arb_state_e;

    // Data captured on completion: read data only for reads that really finished.
    function automatic logic [SPI_FRAME_WIDTH-1:0] resp_data(
        input logic                       is_read,
        input logic                       phy_ok,
        input logic [SPI_FRAME_WIDTH-1:0] rd_data
    );
        if (is_read && phy_ok) begin
            return rd_data;
        end else begin
            return {SPI_FRAME_WIDTH{1'b0}};
        end
    endfunction

endpackage

// File: rtl/gate_driver_spi_prio_sel.sv
// Two-way fixed-priority selector: requester 0 wins unless requester 1 is starved.
module gate_driver_spi_prio_sel
    import gate_driver_spi_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             i_req0_valid,
    input  logic             i_req1_valid,
    input  logic [CNT_W-1:0] i_starve_cnt,
    output logic             o_gnt_valid,
    output logic             o_gnt_id
);

    // Pick a winner among the valid requesters.
    always_comb begin
        o_gnt_valid = i_req0_valid | i_req1_valid;
        o_gnt_id    = 1'b0;
        if (i_req1_valid && (!i_req0_valid || (i_starve_cnt == CNT_W'(STARVE_MAX)))) begin
            o_gnt_id = 1'b1;
        end else begin
            o_gnt_id = 1'b0;
        end
    end

endmodule

// File: rtl/gate_driver_spi_arbiter.sv
// Arbitrates the init/monitor unit (req0) and the diagnostic host (req1)
// onto a single SPI PHY, one transaction at a time, with a PHY timeout.
module gate_driver_spi_arbiter
    import gate_driver_spi_arbiter_pkg::*;
#(
    parameter int FRAME_W     = SPI_FRAME_WIDTH,
    parameter int ADDR_W      = DATA_WIDTH,
    parameter int TIMEOUT_CYC = 4096,
    parameter int STARVE_MAX  = 4
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic               req0_is_read,
    input  logic [FRAME_W-1:0] req0_wdata,
    input  logic [ADDR_W-1:0]  req0_raddr,
    output logic               req0_ready,
    output logic               req0_done,
    output logic [FRAME_W-1:0] req0_rdata,
    output logic               req0_timeout,
    input  logic               req1_valid,
    input  logic               req1_is_read,
    input  logic [FRAME_W-1:0] req1_wdata,
    input  logic [ADDR_W-1:0]  req1_raddr,
    output logic               req1_ready,
    output logic               req1_done,
    output logic [FRAME_W-1:0] req1_rdata,
    output logic               req1_timeout,
    output logic [FRAME_W-1:0] phy_wr_data,
    output logic [ADDR_W-1:0]  phy_rd_addr,
    output logic               phy_wr_valid,
    output logic               phy_rd_enable,
    input  logic [FRAME_W-1:0] phy_rd_data,
    input  logic               phy_done,
    input  logic               phy_busy,
    output logic               arb_busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    arb_state_e         r_state;
    arb_state_e         w_next_state;
    logic               w_gnt_valid;
    logic               w_gnt_id;
    logic [SC_W-1:0]    r_starve_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic               w_to_hit;
    logic               w_resp;
    logic [FRAME_W-1:0] w_resp_data;
    logic               r_owner;
    logic               r_is_read;
    logic [FRAME_W-1:0] r_phy_wr_data;
    logic [ADDR_W-1:0]  r_phy_rd_addr;
    logic               r_phy_wr_valid;
    logic               r_phy_rd_enable;
    logic               r_req0_ready;
    logic               r_req1_ready;
    logic               r_req0_done;
    logic               r_req1_done;
    logic               r_req0_timeout;
    logic               r_req1_timeout;
    logic [FRAME_W-1:0] r_req0_rdata;
    logic [FRAME_W-1:0] r_req1_rdata;
    logic               r_arb_busy;

    gate_driver_spi_prio_sel #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (SC_W)
    ) u_prio_sel (
        .i_req0_valid (req0_valid),
        .i_req1_valid (req1_valid),
        .i_starve_cnt (r_starve_cnt),
        .o_gnt_valid  (w_gnt_valid),
        .o_gnt_id     (w_gnt_id)
    );

    // phy_done wins over a simultaneous timeout, so a late-but-valid answer is kept.
    assign w_to_hit    = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign w_resp      = (r_state == ST_WAIT_DONE) && (phy_done || w_to_hit);
    assign w_resp_data = FRAME_W'(resp_data(r_is_read, phy_done, SPI_FRAME_WIDTH'(phy_rd_data)));

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) w_next_state = ST_ISSUE;
                else             w_next_state = ST_IDLE;
            end
            ST_ISSUE: begin
                if (!phy_busy) w_next_state = ST_WAIT_DONE;
                else           w_next_state = ST_ISSUE;
            end
            ST_WAIT_DONE: begin
                if (phy_done || w_to_hit) w_next_state = ST_RESPOND;
                else                      w_next_state = ST_WAIT_DONE;
            end
            ST_RESPOND: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Count consecutive req0 wins while req1 waits; saturates at STARVE_MAX.
    always_ff @(posedge sys_clk) begin
        if (reset || !req1_valid) begin
            r_starve_cnt <= {SC_W{1'b0}};
        end else if ((r_state == ST_IDLE) && w_gnt_valid) begin
            if (w_gnt_id) begin
                r_starve_cnt <= {SC_W{1'b0}};
            end else if (r_starve_cnt != SC_W'(STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + SC_W'(1);
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

    // Grant: pulse the winner's ready and latch its payload and identity.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_req0_ready  <= 1'b0;
            r_req1_ready  <= 1'b0;
            r_owner       <= 1'b0;
            r_is_read     <= 1'b0;
            r_phy_wr_data <= {FRAME_W{1'b0}};
            r_phy_rd_addr <= {ADDR_W{1'b0}};
        end else if ((r_state == ST_IDLE) && w_gnt_valid) begin
            r_req0_ready  <= ~w_gnt_id;
            r_req1_ready  <= w_gnt_id;
            r_owner       <= w_gnt_id;
            r_is_read     <= w_gnt_id ? req1_is_read : req0_is_read;
            r_phy_wr_data <= w_gnt_id ? req1_wdata : req0_wdata;
            r_phy_rd_addr <= w_gnt_id ? req1_raddr : req0_raddr;
        end else begin
            r_req0_ready  <= 1'b0;
            r_req1_ready  <= 1'b0;
        end
    end

    // PHY start strobe once the PHY is free, and the issue-to-done timeout counter.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_phy_wr_valid  <= 1'b0;
            r_phy_rd_enable <= 1'b0;
            r_to_cnt        <= {TO_W{1'b0}};
        end else begin
            r_phy_wr_valid  <= 1'b0;
            r_phy_rd_enable <= 1'b0;
            if ((r_state == ST_ISSUE) && !phy_busy) begin
                r_phy_wr_valid  <= ~r_is_read;
                r_phy_rd_enable <= r_is_read;
                r_to_cnt        <= {TO_W{1'b0}};
            end else if ((r_state == ST_WAIT_DONE) && !w_resp) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= r_to_cnt;
            end
        end
    end

    // Completion: owner's done/timeout pulse; rdata holds between completions.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_req0_done    <= 1'b0;
            r_req1_done    <= 1'b0;
            r_req0_timeout <= 1'b0;
            r_req1_timeout <= 1'b0;
            r_req0_rdata   <= {FRAME_W{1'b0}};
            r_req1_rdata   <= {FRAME_W{1'b0}};
        end else begin
            r_req0_done    <= w_resp && !r_owner;
            r_req1_done    <= w_resp && r_owner;
            r_req0_timeout <= w_resp && !r_owner && !phy_done;
            r_req1_timeout <= w_resp && r_owner && !phy_done;
            if (w_resp && !r_owner) r_req0_rdata <= w_resp_data;
            else                    r_req0_rdata <= r_req0_rdata;
            if (w_resp && r_owner)  r_req1_rdata <= w_resp_data;
            else                    r_req1_rdata <= r_req1_rdata;
        end
    end

    // Busy flag tracks the state the FSM is entering.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_arb_busy <= 1'b0;
        end else begin
            r_arb_busy <= (w_next_state != ST_IDLE);
        end
    end

    assign req0_ready    = r_req0_ready;
    assign req1_ready    = r_req1_ready;
    assign req0_done     = r_req0_done;
    assign req1_done     = r_req1_done;
    assign req0_timeout  = r_req0_timeout;
    assign req1_timeout  = r_req1_timeout;
    assign req0_rdata    = r_req0_rdata;
    assign req1_rdata    = r_req1_rdata;
    assign phy_wr_data   = r_phy_wr_data;
    assign phy_rd_addr   = r_phy_rd_addr;
    assign phy_wr_valid  = r_phy_wr_valid;
    assign phy_rd_enable = r_phy_rd_enable;
    assign arb_busy      = r_arb_busy;

endmodule

// File: tb/tb_gate_driver_spi_arbiter.sv
// Self-checking bench: transaction-level timing/arbitration model with random traffic.
module tb_gate_driver_spi_arbiter;

    localparam int FW     = 16;
    localparam int AW     = 16;
    localparam int TO_CYC = 32;
    localparam int STARVE = 4;

    logic          sys_clk;
    logic          reset;
    logic          req0_valid, req0_is_read, req0_ready, req0_done, req0_timeout;
    logic [FW-1:0] req0_wdata, req0_rdata;
    logic [AW-1:0] req0_raddr;
    logic          req1_valid, req1_is_read, req1_ready, req1_done, req1_timeout;
    logic [FW-1:0] req1_wdata, req1_rdata;
    logic [AW-1:0] req1_raddr;
    logic [FW-1:0] phy_wr_data, phy_rd_data;
    logic [AW-1:0] phy_rd_addr;
    logic          phy_wr_valid, phy_rd_enable, phy_done, phy_busy, arb_busy;

    int            n_cmp;
    int            n_err;
    logic [FW-1:0] last_rdata [2];

    gate_driver_spi_arbiter #(
        .FRAME_W(FW), .ADDR_W(AW), .TIMEOUT_CYC(TO_CYC), .STARVE_MAX(STARVE)
    ) dut (
        .sys_clk(sys_clk), .reset(reset),
        .req0_valid(req0_valid), .req0_is_read(req0_is_read), .req0_wdata(req0_wdata),
        .req0_raddr(req0_raddr), .req0_ready(req0_ready), .req0_done(req0_done),
        .req0_rdata(req0_rdata), .req0_timeout(req0_timeout),
        .req1_valid(req1_valid), .req1_is_read(req1_is_read), .req1_wdata(req1_wdata),
        .req1_raddr(req1_raddr), .req1_ready(req1_ready), .req1_done(req1_done),
        .req1_rdata(req1_rdata), .req1_timeout(req1_timeout),
        .phy_wr_data(phy_wr_data), .phy_rd_addr(phy_rd_addr), .phy_wr_valid(phy_wr_valid),
        .phy_rd_enable(phy_rd_enable), .phy_rd_data(phy_rd_data), .phy_done(phy_done),
        .phy_busy(phy_busy), .arb_busy(arb_busy)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic v, input logic rd,
                           input logic [FW-1:0] wd, input logic [AW-1:0] ra);
        if (id == 0) begin
            req0_valid = v; req0_is_read = rd; req0_wdata = wd; req0_raddr = ra;
        end else begin
            req1_valid = v; req1_is_read = rd; req1_wdata = wd; req1_raddr = ra;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_pulses"}, {23'd0, req0_ready, req1_ready, req0_done, req1_done,
                 req0_timeout, req1_timeout, phy_wr_valid, phy_rd_enable, arb_busy}, 32'd0);
        check_eq({tag, "_rdata0"}, {16'd0, req0_rdata}, 32'd0);
        check_eq({tag, "_rdata1"}, {16'd0, req1_rdata}, 32'd0);
        check_eq({tag, "_phy_wd"}, {16'd0, phy_wr_data}, 32'd0);
        check_eq({tag, "_phy_ra"}, {16'd0, phy_rd_addr}, 32'd0);
    endtask

    // One transaction from an idle arbiter. Cycle 0 = valid raised; ready at 1;
    // strobe at s_c = busy_n+2; done one cycle after phy_done, or TO_CYC after strobe.
    task automatic do_txn(input int id, input logic rd, input logic [FW-1:0] wd,
                          input logic [AW-1:0] ra, input logic [FW-1:0] rdv,
                          input int busy_n, input int lat);
        int            s_c, d_c;
        logic          to_exp;
        logic [FW-1:0] exp_rd;
        logic [5:0]    exp_v, got_v;
        s_c = busy_n + 2;
        if (lat <= TO_CYC - 1) begin
            d_c = s_c + lat + 1; to_exp = 1'b0;
        end else begin
            d_c = s_c + TO_CYC; to_exp = 1'b1;
        end
        exp_rd = (to_exp || !rd) ? 16'h0000 : rdv;
        set_req(id, 1'b1, rd, wd, ra);
        phy_busy    = 1'b0;
        phy_done    = 1'($urandom_range(0, 1));
        phy_rd_data = 16'($urandom);
        for (int c = 1; c <= d_c + 1; c++) begin
            step();
            exp_v = {(c == 1) && (id == 0), (c == 1) && (id == 1), (c == s_c) && !rd,
                     (c == s_c) && rd, (c == d_c) && (id == 0), (c == d_c) && (id == 1)};
            got_v = {req0_ready, req1_ready, phy_wr_valid, phy_rd_enable, req0_done, req1_done};
            check_eq("pulses", {26'd0, got_v}, {26'd0, exp_v});
            check_eq("arb_busy", {31'd0, arb_busy}, {31'd0, (c <= d_c)});
            if (c < d_c) begin
                check_eq("phy_wr_data", {16'd0, phy_wr_data}, {16'd0, wd});
                check_eq("phy_rd_addr", {16'd0, phy_rd_addr}, {16'd0, ra});
            end
            if (c == d_c) begin
                if (id == 0) begin
                    check_eq("own_rdata", {16'd0, req0_rdata}, {16'd0, exp_rd});
                    check_eq("own_timeout", {31'd0, req0_timeout}, {31'd0, to_exp});
                    check_eq("other_rdata", {16'd0, req1_rdata}, {16'd0, last_rdata[1]});
                    check_eq("other_timeout", {31'd0, req1_timeout}, 32'd0);
                end else begin
                    check_eq("own_rdata", {16'd0, req1_rdata}, {16'd0, exp_rd});
                    check_eq("own_timeout", {31'd0, req1_timeout}, {31'd0, to_exp});
                    check_eq("other_rdata", {16'd0, req0_rdata}, {16'd0, last_rdata[0]});
                    check_eq("other_timeout", {31'd0, req0_timeout}, 32'd0);
                end
                last_rdata[id] = exp_rd;
            end
            if (c == 1) set_req(id, 1'b0, 1'b0, 16'h0000, 16'h0000);
            phy_busy    = (c <= busy_n);
            phy_done    = 1'b0;
            phy_rd_data = 16'($urandom);
            if ((c < s_c) || (c == d_c)) begin
                phy_done = 1'($urandom_range(0, 1));
            end else if (!to_exp && (c == s_c + lat)) begin
                phy_done    = 1'b1;
                phy_rd_data = rdv;
            end
        end
        phy_done = 1'b0;
        phy_busy = 1'b0;
    endtask

    // Both requesters held valid: grant order follows the starvation rule.
    task automatic arb_test();
        int grants[$];
        int n_model, exp_id, wait_c;
        set_req(0, 1'b1, 1'b0, 16'h1111, 16'h0000);
        set_req(1, 1'b1, 1'b1, 16'h0000, 16'h0002);
        phy_busy = 1'b0; phy_done = 1'b0; phy_rd_data = 16'hA5A5;
        wait_c = 0;
        while ((grants.size() < 10) && (wait_c < 400)) begin
            step();
            wait_c++;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (req1_done) check_eq("arb_rdata", {16'd0, req1_rdata}, 32'h0000A5A5);
            phy_done = phy_wr_valid | phy_rd_enable;
        end
        set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_req(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check_eq("arb_count", grants.size(), 32'd10);
        n_model = 0;
        foreach (grants[i]) begin
            if (n_model == STARVE) begin exp_id = 1; n_model = 0; end
            else begin exp_id = 0; n_model++; end
            check_eq("arb_order", grants[i], exp_id);
        end
        for (int c = 0; (c < 60) && arb_busy; c++) begin
            step();
            phy_done = phy_wr_valid | phy_rd_enable;
        end
        phy_done = 1'b0;
        check_eq("arb_drain", {31'd0, arb_busy}, 32'd0);
        check_eq("arb_last1", {16'd0, req1_rdata}, 32'h0000A5A5);
        last_rdata[0] = 16'h0000;
        last_rdata[1] = 16'hA5A5;
    endtask

    // Reset while waiting on the PHY, then a stale phy_done.
    task automatic reset_test();
        set_req(0, 1'b1, 1'b1, 16'h0000, 16'h0033);
        phy_busy = 1'b0; phy_done = 1'b0;
        step();
        check_eq("rst_ready", {31'd0, req0_ready}, 32'd1);
        set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        step();
        check_eq("rst_strobe", {31'd0, phy_rd_enable}, 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("rst_mid");
        phy_done = 1'b1; phy_rd_data = 16'hFFFF;
        step();
        phy_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_all_zero("rst_stale");
            step();
        end
        last_rdata[0] = 16'h0000;
        last_rdata[1] = 16'h0000;
    endtask

    initial begin
        int id, busy_n, lat, sel;
        logic rd;
        n_cmp = 0; n_err = 0;
        last_rdata[0] = 16'h0000; last_rdata[1] = 16'h0000;
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_req(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        phy_busy = 1'b0; phy_done = 1'b0; phy_rd_data = 16'h0000;
        repeat (3) step();
        check_all_zero("por");
        reset = 1'b0;

        do_txn(0, 1'b0, 16'h1234, 16'h0000, 16'h0000, 0, 4);
        do_txn(1, 1'b1, 16'h0000, 16'h0002, 16'hA5A5, 0, 2);
        do_txn(0, 1'b0, 16'hBEEF, 16'h0007, 16'h0000, 10, 3);
        do_txn(1, 1'b1, 16'h0000, 16'h0044, 16'h5A5A, 0, TO_CYC + 10);
        do_txn(0, 1'b1, 16'h0000, 16'h0055, 16'hC3C3, 1, TO_CYC - 1);
        do_txn(1, 1'b1, 16'h0000, 16'h0066, 16'h7E7E, 0, 0);

        arb_test();
        reset_test();

        for (int k = 0; k < 40; k++) begin
            id     = $urandom_range(0, 1);
            rd     = 1'($urandom_range(0, 1));
            busy_n = $urandom_range(0, 3);
            sel    = $urandom_range(0, 9);
            if (sel == 0)      lat = TO_CYC - 1;
            else if (sel == 1) lat = TO_CYC + 3;
            else               lat = $urandom_range(0, 6);
            do_txn(id, rd, 16'($urandom), 16'($urandom), 16'($urandom), busy_n, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
